mod_memstage_lsu: RTL and testbench

- Memory stage directly upstream of the execute stage.
- Accepts one decoded, register-read instruction at a time and performs its load or store on the data-memory port; loads cover mov-load 0x8B and POP 0x58-0x5F.
- Returns the load data in load_buffer and hands the packed MEM_EX record to execute over a valid/ready handshake.
- Drives store_memstage_active while a store is in flight and supports a pipeline flush on jump resteer.

---
 rtl/mod_memstage_lsu.sv | 194 +++++++++++++++++++
 tb/tb_mod_memstage_lsu.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mod_memstage_lsu.sv
// Memory stage load/store unit: issues one load or store per accepted
// instruction on the data-memory port, captures the load data and hands the
// packed MEM_EX record downstream over a valid/ready handshake.
module mod_memstage_lsu #(
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64,
  parameter int TIMEOUT = 255,
  localparam int MEMEX_W = 276
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [MEMEX_W-1:0] in_memex,
  input  logic [1:0]         in_mem_op,
  input  logic [ADDR_W-1:0]  in_addr,
  input  logic [DATA_W-1:0]  in_wdata,
  output logic               req_valid,
  input  logic               req_ready,
  output logic               req_we,
  output logic [ADDR_W-1:0]  req_addr,
  output logic [DATA_W-1:0]  req_wdata,
  input  logic               resp_valid,
  input  logic [DATA_W-1:0]  resp_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [MEMEX_W-1:0] memex,
  output logic [DATA_W-1:0]  load_buffer,
  output logic               loadbuffer_done,
  output logic               store_memstage_active,
  output logic               mem_error
);

  // Counter just wide enough to reach TIMEOUT; one extra bit for the increment.
  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W:0] TIMEOUT_VAL = (CNT_W + 1)'(TIMEOUT);

  localparam logic [1:0] OPK_NONE  = 2'd0;
  localparam logic [1:0] OPK_LOAD  = 2'd1;
  localparam logic [1:0] OPK_STORE = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_HOLD  = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  state_t           state;
  logic             is_store;
  logic [CNT_W-1:0] wait_cnt;

  logic [1:0]       op_kind;
  logic             accept;
  logic [CNT_W:0]   cnt_inc;
  logic             timeout_hit;
  logic             discard;

  assign in_ready = (state == S_IDLE) && !flush;
  assign accept   = in_valid && in_ready;

  // Effective memory operation: sim_end (LSB of MEM_EX) forces a pass-through.
  always_comb begin
    op_kind = OPK_NONE;
    if (in_memex[0]) begin
      op_kind = OPK_NONE;
    end else begin
      case (in_mem_op)
        2'd1:    op_kind = OPK_LOAD;
        2'd2:    op_kind = OPK_STORE;
        default: op_kind = OPK_NONE;
      endcase
    end
  end

  // The timeout fires at the end of the TIMEOUT-th cycle spent waiting without a response.
  always_comb begin
    cnt_inc     = {1'b0, wait_cnt} + {{CNT_W{1'b0}}, 1'b1};
    timeout_hit = 1'b0;
    if (TIMEOUT != 0) begin
      timeout_hit = (cnt_inc == TIMEOUT_VAL);
    end else begin
      timeout_hit = 1'b0;
    end
    // A flush while waiting turns the outstanding access into a drain.
    discard = (state == S_DRAIN) || flush;
  end

  // Stage FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state                 <= S_IDLE;
      is_store              <= 1'b0;
      wait_cnt              <= {CNT_W{1'b0}};
      req_valid             <= 1'b0;
      req_we                <= 1'b0;
      req_addr              <= {ADDR_W{1'b0}};
      req_wdata             <= {DATA_W{1'b0}};
      out_valid             <= 1'b0;
      memex                 <= {MEMEX_W{1'b0}};
      load_buffer           <= {DATA_W{1'b0}};
      loadbuffer_done       <= 1'b0;
      store_memstage_active <= 1'b0;
      mem_error             <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            memex     <= in_memex;
            req_addr  <= in_addr;
            req_wdata <= in_wdata;
            is_store  <= (op_kind == OPK_STORE);
            if (op_kind == OPK_NONE) begin
              state     <= S_HOLD;
              out_valid <= 1'b1;
            end else begin
              state                 <= S_REQ;
              req_valid             <= 1'b1;
              req_we                <= (op_kind == OPK_STORE);
              store_memstage_active <= (op_kind == OPK_STORE);
              if (op_kind == OPK_LOAD) begin
                loadbuffer_done <= 1'b0;
              end
            end
          end
        end
        S_REQ: begin
          if (flush) begin
            req_valid <= 1'b0;
            req_we    <= 1'b0;
            if (req_ready) begin
              // Memory took the request in the flush cycle: its response must still be absorbed.
              state    <= S_DRAIN;
              wait_cnt <= {CNT_W{1'b0}};
            end else begin
              state                 <= S_IDLE;
              store_memstage_active <= 1'b0;
            end
          end else if (req_ready) begin
            state     <= S_WAIT;
            req_valid <= 1'b0;
            req_we    <= 1'b0;
            wait_cnt  <= {CNT_W{1'b0}};
          end
        end
        S_WAIT, S_DRAIN: begin
          if (resp_valid || timeout_hit) begin
            store_memstage_active <= 1'b0;
            if (!resp_valid) begin
              mem_error <= 1'b1;
            end
            if (discard) begin
              state <= S_IDLE;
            end else begin
              state     <= S_HOLD;
              out_valid <= 1'b1;
              if (resp_valid) begin
                if (!is_store) begin
                  load_buffer     <= resp_data;
                  loadbuffer_done <= 1'b1;
                end
              end else begin
                load_buffer <= {DATA_W{1'b0}};
              end
            end
          end else begin
            wait_cnt <= cnt_inc[CNT_W-1:0];
            if (discard) begin
              state <= S_DRAIN;
            end
          end
        end
        S_HOLD: begin
          if (flush || out_ready) begin
            state           <= S_IDLE;
            out_valid       <= 1'b0;
            loadbuffer_done <= 1'b0;
          end
        end
        default: begin
          state                 <= S_IDLE;
          req_valid             <= 1'b0;
          req_we                <= 1'b0;
          out_valid             <= 1'b0;
          loadbuffer_done       <= 1'b0;
          store_memstage_active <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mod_memstage_lsu.sv
// Randomized self-checking bench for mod_memstage_lsu with a transaction-timing
// reference model (delays in, expected per-cycle outputs out).
module tb_mod_memstage_lsu;

  localparam int TO = 4;
  typedef logic [275:0] wide_t;

  logic         clk;
  logic         reset;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [275:0] in_memex;
  logic [1:0]   in_mem_op;
  logic [63:0]  in_addr;
  logic [63:0]  in_wdata;
  logic         req_valid;
  logic         req_ready;
  logic         req_we;
  logic [63:0]  req_addr;
  logic [63:0]  req_wdata;
  logic         resp_valid;
  logic [63:0]  resp_data;
  logic         out_valid;
  logic         out_ready;
  logic [275:0] memex;
  logic [63:0]  load_buffer;
  logic         loadbuffer_done;
  logic         store_memstage_active;
  logic         mem_error;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state that persists across transactions.
  logic [63:0] exp_lb  = 64'd0;
  logic        exp_err = 1'b0;

  mod_memstage_lsu #(.ADDR_W(64), .DATA_W(64), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_memex(in_memex),
    .in_mem_op(in_mem_op), .in_addr(in_addr), .in_wdata(in_wdata),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_data(resp_data),
    .out_valid(out_valid), .out_ready(out_ready), .memex(memex),
    .load_buffer(load_buffer), .loadbuffer_done(loadbuffer_done),
    .store_memstage_active(store_memstage_active), .mem_error(mem_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard bound on total runtime.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input wide_t got, input wide_t exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_ov"},   wide_t'(out_valid), wide_t'(1'b0));
    check_eq({tag, "_rv"},   wide_t'(req_valid), wide_t'(1'b0));
    check_eq({tag, "_we"},   wide_t'(req_we), wide_t'(1'b0));
    check_eq({tag, "_ra"},   wide_t'(req_addr), wide_t'(64'd0));
    check_eq({tag, "_rw"},   wide_t'(req_wdata), wide_t'(64'd0));
    check_eq({tag, "_mx"},   memex, wide_t'(1'b0));
    check_eq({tag, "_lb"},   wide_t'(load_buffer), wide_t'(64'd0));
    check_eq({tag, "_lbd"},  wide_t'(loadbuffer_done), wide_t'(1'b0));
    check_eq({tag, "_sma"},  wide_t'(store_memstage_active), wide_t'(1'b0));
    check_eq({tag, "_err"},  wide_t'(mem_error), wide_t'(1'b0));
  endtask

  // fmode: 0 none, 1 flush in REQ (not accepted) at REQ cycle fat, 2 flush with
  // req_ready in the accepting cycle, 3 flush in WAIT at wait cycle fat,
  // 4 flush in HOLD at hold cycle fat, 5 reset in HOLD at hold cycle fat.
  task automatic run_txn(input logic [1:0] mem_op, input logic sim_end, input logic [7:0] opcode,
                         input logic [63:0] addr, input logic [63:0] wdata, input logic [63:0] rdata,
                         input int rq_dly, input int rsp_dly, input int hold_dly,
                         input int fmode, input int fat, input logic pre_flush);
    wide_t mx;
    logic  is_ld, is_st, mem, timed_out, discard, exp_done;
    int    n_pend;
    mx = {rand64(), rand64(), rand64(), rand64(), opcode, 1'($urandom), 4'($urandom),
          4'($urandom), 2'($urandom), sim_end};
    is_ld = !sim_end && (mem_op == 2'd1);
    is_st = !sim_end && (mem_op == 2'd2);
    mem   = is_ld || is_st;
    in_memex = mx; in_mem_op = mem_op; in_addr = addr; in_wdata = wdata;
    in_valid = 1'b1;
    if (pre_flush) begin
      flush = 1'b1;
      @(negedge clk);
      check_eq("in_ready_flush", wide_t'(in_ready), wide_t'(1'b0));
      step();
      flush = 1'b0;
    end
    // Accept cycle: still idle, so nothing issued yet.
    @(negedge clk);
    check_eq("in_ready", wide_t'(in_ready), wide_t'(1'b1));
    check_eq("idle_ov", wide_t'(out_valid), wide_t'(1'b0));
    check_eq("idle_rv", wide_t'(req_valid), wide_t'(1'b0));
    step();
    in_valid = 1'b0; in_memex = {rand64(), rand64(), rand64(), rand64(), 20'($urandom)};
    in_addr = rand64(); in_wdata = rand64(); in_mem_op = 2'($urandom);
    exp_done = 1'b0;

    if (mem) begin
      for (int c = 1; c <= rq_dly + 1; c++) begin
        req_ready = (c == rq_dly + 1);
        flush = ((fmode == 1) && (c == fat)) || ((fmode == 2) && (c == rq_dly + 1));
        @(negedge clk);
        check_eq("req_valid", wide_t'(req_valid), wide_t'(1'b1));
        check_eq("req_we", wide_t'(req_we), wide_t'(is_st));
        check_eq("req_addr", wide_t'(req_addr), wide_t'(addr));
        check_eq("req_wdata", wide_t'(req_wdata), wide_t'(wdata));
        check_eq("req_sma", wide_t'(store_memstage_active), wide_t'(is_st));
        check_eq("req_ov", wide_t'(out_valid), wide_t'(1'b0));
        check_eq("req_lbd", wide_t'(loadbuffer_done), wide_t'(1'b0));
        check_eq("req_err", wide_t'(mem_error), wide_t'(exp_err));
        step();
        if ((fmode == 1) && (c == fat)) begin
          flush = 1'b0; req_ready = 1'b0;
          @(negedge clk);
          check_eq("abort_rv", wide_t'(req_valid), wide_t'(1'b0));
          check_eq("abort_sma", wide_t'(store_memstage_active), wide_t'(1'b0));
          check_eq("abort_ov", wide_t'(out_valid), wide_t'(1'b0));
          check_eq("abort_in_ready", wide_t'(in_ready), wide_t'(1'b1));
          check_eq("abort_lb", wide_t'(load_buffer), wide_t'(exp_lb));
          step();
          return;
        end
      end
      req_ready = 1'b0; flush = 1'b0;

      discard   = (fmode == 2);
      n_pend    = (rsp_dly + 1 <= TO) ? rsp_dly + 1 : TO;
      timed_out = (rsp_dly >= TO);
      for (int c = 1; c <= n_pend; c++) begin
        resp_valid = (c == rsp_dly + 1);
        resp_data  = resp_valid ? rdata : rand64();
        flush      = (fmode == 3) && (c == fat);
        @(negedge clk);
        check_eq("pend_rv", wide_t'(req_valid), wide_t'(1'b0));
        check_eq("pend_ov", wide_t'(out_valid), wide_t'(1'b0));
        check_eq("pend_sma", wide_t'(store_memstage_active), wide_t'(is_st));
        check_eq("pend_in_ready", wide_t'(in_ready), wide_t'(1'b0));
        check_eq("pend_err", wide_t'(mem_error), wide_t'(exp_err));
        step();
        if (flush) discard = 1'b1;
      end
      resp_valid = 1'b0; flush = 1'b0;
      if (timed_out) exp_err = 1'b1;
      if (discard) begin
        @(negedge clk);
        check_eq("drain_ov", wide_t'(out_valid), wide_t'(1'b0));
        check_eq("drain_in_ready", wide_t'(in_ready), wide_t'(1'b1));
        check_eq("drain_sma", wide_t'(store_memstage_active), wide_t'(1'b0));
        check_eq("drain_err", wide_t'(mem_error), wide_t'(exp_err));
        check_eq("drain_lb", wide_t'(load_buffer), wide_t'(exp_lb));
        check_eq("drain_lbd", wide_t'(loadbuffer_done), wide_t'(1'b0));
        step();
        return;
      end
      if (timed_out) exp_lb = 64'd0;
      else if (is_ld) exp_lb = rdata;
      exp_done = is_ld && !timed_out;
    end

    for (int c = 1; c <= hold_dly + 1; c++) begin
      out_ready  = (fmode == 5) ? 1'b0 : (c == hold_dly + 1);
      flush      = (fmode == 4) && (c == fat);
      reset      = !((fmode == 5) && (c == fat));
      resp_valid = 1'($urandom);
      resp_data  = rand64();
      @(negedge clk);
      check_eq("hold_ov", wide_t'(out_valid), wide_t'(1'b1));
      check_eq("hold_memex", memex, mx);
      check_eq("hold_lb", wide_t'(load_buffer), wide_t'(exp_lb));
      check_eq("hold_lbd", wide_t'(loadbuffer_done), wide_t'(exp_done));
      check_eq("hold_sma", wide_t'(store_memstage_active), wide_t'(1'b0));
      check_eq("hold_rv", wide_t'(req_valid), wide_t'(1'b0));
      check_eq("hold_in_ready", wide_t'(in_ready), wide_t'(1'b0));
      check_eq("hold_err", wide_t'(mem_error), wide_t'(exp_err));
      step();
      if (flush || !reset) break;
    end
    out_ready = 1'b0; flush = 1'b0;

    if (!reset) begin
      // Reset taken; a late response in the following idle cycles must be ignored.
      reset = 1'b1; resp_valid = 1'b1; resp_data = rand64();
      exp_lb = 64'd0; exp_err = 1'b0;
      @(negedge clk);
      check_all_zero("rst_hold");
      check_eq("rst_in_ready", wide_t'(in_ready), wide_t'(1'b1));
      step();
      resp_valid = 1'b0;
      @(negedge clk);
      check_eq("late_ov", wide_t'(out_valid), wide_t'(1'b0));
      check_eq("late_lb", wide_t'(load_buffer), wide_t'(64'd0));
      check_eq("late_lbd", wide_t'(loadbuffer_done), wide_t'(1'b0));
      check_eq("late_in_ready", wide_t'(in_ready), wide_t'(1'b1));
      step();
      return;
    end

    resp_valid = 1'b0;
    @(negedge clk);
    check_eq("done_ov", wide_t'(out_valid), wide_t'(1'b0));
    check_eq("done_lbd", wide_t'(loadbuffer_done), wide_t'(1'b0));
    check_eq("done_in_ready", wide_t'(in_ready), wide_t'(1'b1));
    check_eq("done_lb", wide_t'(load_buffer), wide_t'(exp_lb));
    check_eq("done_err", wide_t'(mem_error), wide_t'(exp_err));
    step();
  endtask

  initial begin
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; in_memex = '0; in_mem_op = 2'd0;
    in_addr = 64'd0; in_wdata = 64'd0; req_ready = 1'b0; resp_valid = 1'b0;
    resp_data = 64'd0; out_ready = 1'b0;
    step(); step(); step();
    @(negedge clk);
    check_all_zero("reset");
    step();
    reset = 1'b1;

    // Register-only op, immediate handoff.
    run_txn(2'd0, 1'b0, 8'h01, 64'h20, rand64(), 64'd0, 0, 0, 0, 0, 0, 1'b0);
    // Load 0x8B at 0x1000, response two cycles into the wait.
    run_txn(2'd1, 1'b0, 8'h8B, 64'h1000, rand64(), 64'hDEADBEEFCAFEF00D, 0, 1, 0, 0, 0, 1'b0);
    // Store with req_ready low for three cycles.
    run_txn(2'd2, 1'b0, 8'h89, 64'h2008, 64'h0123456789ABCDEF, 64'd0, 3, 1, 1, 0, 0, 1'b0);
    // Load flushed in WAIT, then drained.
    run_txn(2'd1, 1'b0, 8'h8B, 64'h3000, rand64(), rand64(), 0, 2, 0, 3, 1, 1'b0);
    // POP with no response: timeout, load_buffer cleared, mem_error set.
    run_txn(2'd1, 1'b0, 8'h5A, 64'h4000, rand64(), rand64(), 1, 6, 1, 0, 0, 1'b0);
    // mem_error stays set across a normal load.
    run_txn(2'd1, 1'b0, 8'h8B, 64'h4008, rand64(), rand64(), 0, 0, 0, 0, 0, 1'b0);
    // Reset while holding with out_ready low.
    run_txn(2'd1, 1'b0, 8'h8B, 64'h5000, rand64(), rand64(), 0, 0, 3, 5, 2, 1'b0);
    // sim_end and reserved op pass through as none; flushes in REQ and HOLD; blocked accept.
    run_txn(2'd1, 1'b1, 8'h8B, 64'h6000, rand64(), rand64(), 0, 0, 0, 0, 0, 1'b0);
    run_txn(2'd3, 1'b0, 8'h02, 64'h6008, rand64(), rand64(), 0, 0, 1, 0, 0, 1'b1);
    run_txn(2'd2, 1'b0, 8'h89, 64'h7000, rand64(), rand64(), 2, 0, 0, 1, 2, 1'b0);
    run_txn(2'd2, 1'b0, 8'h89, 64'h7008, rand64(), rand64(), 1, 2, 0, 2, 0, 1'b0);
    run_txn(2'd1, 1'b0, 8'h8B, 64'h7010, rand64(), rand64(), 0, 0, 2, 4, 2, 1'b0);

    for (int i = 0; i < 250; i++) begin
      logic [1:0] op;
      logic       se, is_mem;
      int         rq, rs, hd, fm, fa, np;
      op = 2'($urandom_range(0, 3));
      se = ($urandom_range(0, 7) == 0);
      rq = $urandom_range(0, 3);
      rs = $urandom_range(0, 6);
      hd = $urandom_range(0, 2);
      is_mem = !se && ((op == 2'd1) || (op == 2'd2));
      fm = 0; fa = 0;
      case ($urandom_range(0, 9))
        5: fm = 1;
        6: fm = 2;
        7: fm = 3;
        8: fm = 4;
        9: fm = ($urandom_range(0, 3) == 0) ? 5 : 0;
        default: fm = 0;
      endcase
      if (!is_mem && (fm >= 1) && (fm <= 3)) fm = 0;
      if ((fm == 1) && (rq == 0)) fm = 0;
      np = (rs + 1 <= TO) ? rs + 1 : TO;
      if (fm == 1) fa = $urandom_range(1, rq);
      if (fm == 3) fa = $urandom_range(1, np);
      if ((fm == 4) || (fm == 5)) fa = $urandom_range(1, hd + 1);
      run_txn(op, se, (op == 2'd1) ? 8'($urandom_range(8'h58, 8'h5F)) : 8'($urandom),
              rand64(), rand64(), rand64(), rq, rs, hd, fm, fa, ($urandom_range(0, 3) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
